// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared types and constants for the cache miss arbiter
package cache_pkg;

    localparam int ADDR_W_DEF = 64;
    localparam int DATA_W_DEF = 64;

    // Requester indices into the two-bit request/grant vectors
    localparam int REQ_I = 0;
    localparam int REQ_D = 1;

    localparam int CNT_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-way round-robin grant; priority flips only on ties
module rr_arbiter2
    import cache_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [1:0] req,
    input  logic       advance,
    output logic [1:0] grant
);

    // 1: D wins the next tie, 0: I wins the next tie
    logic prio_d;

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = 2'b00;
            if (prio_d) begin
                grant[REQ_D] = 1'b1;
            end else begin
                grant[REQ_I] = 1'b1;
            end
        end
    end

    // A lone requester does not move the pointer, so a tie loser keeps its claim
    always_ff @(posedge clk) begin
        if (reset) begin
            prio_d <= 1'b1;
        end else if (advance && (req == 2'b11)) begin
            prio_d <= ~prio_d;
        end
    end

endmodule

// File: rtl/cache_miss_arbiter.sv
// rtl/cache_miss_arbiter.sv - shares one L2 port between instruction and data L1 misses
module cache_miss_arbiter
    import cache_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_ack,
    output logic [31:0]       i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ack,
    output logic [DATA_W-1:0] d_rdata,
    output logic              l2_req,
    output logic              l2_we,
    output logic [ADDR_W-1:0] l2_addr,
    output logic [DATA_W-1:0] l2_wdata,
    input  logic [DATA_W-1:0] l2_rdata,
    input  logic              l2_ready,
    output logic              busy,
    output logic              err
);

    localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'(TIMEOUT - 1);

    state_t            state;
    state_t            state_nx;
    logic [1:0]        arb_req;
    logic [1:0]        grant;
    logic              arb_advance;
    logic              granted;
    logic              gnt_d;
    logic [ADDR_W-1:0] addr_q;
    logic              we_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata_q;
    logic [CNT_W-1:0]  wait_cnt;
    logic              timeout_q;
    logic              wait_expired;

    assign arb_req[REQ_I] = i_req;
    assign arb_req[REQ_D] = d_req;
    assign arb_advance    = (state == ST_IDLE);
    assign granted        = |grant;

    rr_arbiter2 u_rr (
        .clk     (clk),
        .reset   (reset),
        .req     (arb_req),
        .advance (arb_advance),
        .grant   (grant)
    );

    // Ready wins over expiry when both land on the last WAIT cycle
    assign wait_expired = (state == ST_WAIT) && !l2_ready && (wait_cnt == LAST_WAIT);

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        busy     = 1'b1;
        l2_req   = 1'b0;
        i_ack    = 1'b0;
        d_ack    = 1'b0;
        err      = 1'b0;
        case (state)
            ST_IDLE: begin
                busy = 1'b0;
                if (granted) begin
                    state_nx = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                l2_req   = 1'b1;
                state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                l2_req = 1'b1;
                if (l2_ready || wait_expired) begin
                    state_nx = ST_RESP;
                end
            end
            ST_RESP: begin
                i_ack    = ~gnt_d;
                d_ack    = gnt_d;
                err      = timeout_q;
                state_nx = ST_IDLE;
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            gnt_d     <= 1'b0;
            addr_q    <= '0;
            we_q      <= 1'b0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            wait_cnt  <= '0;
            timeout_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (granted) begin
                        gnt_d     <= grant[REQ_D];
                        addr_q    <= grant[REQ_D] ? d_addr : i_addr;
                        we_q      <= grant[REQ_D] & d_we;
                        wdata_q   <= grant[REQ_D] ? d_wdata : '0;
                        timeout_q <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt <= '0;
                end
                ST_WAIT: begin
                    if (l2_ready) begin
                        rdata_q <= l2_rdata;
                    end else if (wait_expired) begin
                        rdata_q   <= '0;
                        timeout_q <= 1'b1;
                        wait_cnt  <= wait_cnt + 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign l2_we    = l2_req & we_q;
    assign l2_addr  = addr_q;
    assign l2_wdata = wdata_q;
    assign i_rdata  = rdata_q[31:0];
    assign d_rdata  = rdata_q;

endmodule

// File: tb/tb_cache_miss_arbiter.sv
// tb/tb_cache_miss_arbiter.sv - directed scoreboard bench for cache_miss_arbiter
module tb_cache_miss_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req;
    logic [63:0] i_addr;
    logic        i_ack;
    logic [31:0] i_rdata;
    logic        d_req;
    logic        d_we;
    logic [63:0] d_addr;
    logic [63:0] d_wdata;
    logic        d_ack;
    logic [63:0] d_rdata;
    logic        l2_req;
    logic        l2_we;
    logic [63:0] l2_addr;
    logic [63:0] l2_wdata;
    logic [63:0] l2_rdata;
    logic        l2_ready;
    logic        busy;
    logic        err;

    typedef struct {
        bit          is_d;
        logic [63:0] rdata;
        bit          err;
    } exp_t;

    exp_t sb[$];
    int   vectors    = 0;
    int   miscompares = 0;

    cache_miss_arbiter dut (
        .clk      (clk),
        .reset    (reset),
        .i_req    (i_req),
        .i_addr   (i_addr),
        .i_ack    (i_ack),
        .i_rdata  (i_rdata),
        .d_req    (d_req),
        .d_we     (d_we),
        .d_addr   (d_addr),
        .d_wdata  (d_wdata),
        .d_ack    (d_ack),
        .d_rdata  (d_rdata),
        .l2_req   (l2_req),
        .l2_we    (l2_we),
        .l2_addr  (l2_addr),
        .l2_wdata (l2_wdata),
        .l2_rdata (l2_rdata),
        .l2_ready (l2_ready),
        .busy     (busy),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_exp(input bit is_d, input logic [63:0] rdata, input bit e);
        exp_t x;
        x.is_d  = is_d;
        x.rdata = rdata;
        x.err   = e;
        sb.push_back(x);
    endtask

    // Response monitor: every ack must match the oldest outstanding expectation
    always @(negedge clk) begin
        if (!reset && (i_ack || d_ack)) begin
            check("dual_ack", {63'b0, i_ack & d_ack}, 64'd0);
            if (sb.size() == 0) begin
                check("spurious_ack", {62'b0, i_ack, d_ack}, 64'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("ack_port", {63'b0, d_ack}, {63'b0, e.is_d});
                if (e.is_d) check("d_rdata", d_rdata, e.rdata);
                else        check("i_rdata", {32'b0, i_rdata}, {32'b0, e.rdata[31:0]});
                check("err_with_ack", {63'b0, err}, {63'b0, e.err});
            end
        end else if (!reset && err) begin
            check("err_without_ack", {63'b0, err}, 64'd0);
        end
    end

    task automatic wait_l2(input string tag);
        int n = 0;
        while (!l2_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_l2_req_seen"}, {63'b0, l2_req}, 64'd1);
    endtask

    task automatic serve_l2(input string tag, input int delay, input logic [63:0] data);
        wait_l2(tag);
        repeat (delay) @(negedge clk);
        l2_ready = 1'b1;
        l2_rdata = data;
        @(negedge clk);
        l2_ready = 1'b0;
        l2_rdata = {$urandom, $urandom};
    endtask

    task automatic wait_ack(input string tag, input int budget);
        int n = 0;
        while (!(i_ack || d_ack) && n < budget) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_ack_seen"}, {63'b0, i_ack | d_ack}, 64'd1);
        if (i_ack) i_req = 1'b0;
        if (d_ack) d_req = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        int req_cycles;
        reset    = 1'b1;
        i_req    = 1'b0;
        i_addr   = '0;
        d_req    = 1'b0;
        d_we     = 1'b0;
        d_addr   = '0;
        d_wdata  = '0;
        l2_rdata = '0;
        l2_ready = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_busy",     {63'b0, busy},   64'd0);
        check("rst_l2_req",   {63'b0, l2_req}, 64'd0);
        check("rst_l2_we",    {63'b0, l2_we},  64'd0);
        check("rst_acks",     {62'b0, i_ack, d_ack}, 64'd0);
        check("rst_err",      {63'b0, err},    64'd0);
        check("rst_l2_addr",  l2_addr,  64'd0);
        check("rst_l2_wdata", l2_wdata, 64'd0);
        check("rst_d_rdata",  d_rdata,  64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Stray l2_ready while idle
        l2_ready = 1'b1;
        l2_rdata = 64'hFFFF_0000_FFFF_0000;
        repeat (2) @(negedge clk);
        l2_ready = 1'b0;
        check("stray_busy",    {63'b0, busy}, 64'd0);
        check("stray_d_rdata", d_rdata, 64'd0);
        @(negedge clk);
        check("stray_still_idle", {63'b0, busy}, 64'd0);

        // First tie after reset: D then I
        i_req  = 1'b1;
        i_addr = 64'h0000_0000_0000_3000;
        d_req  = 1'b1;
        d_we   = 1'b0;
        d_addr = 64'h0000_0000_0000_4000;
        push_exp(1'b1, 64'h1111_2222_3333_4444, 1'b0);
        push_exp(1'b0, 64'h5555_6666_7777_8888, 1'b0);
        wait_l2("tie1_d");
        check("tie1_first_addr", l2_addr, 64'h4000);
        check("tie1_i_waits", {63'b0, i_ack}, 64'd0);
        serve_l2("tie1_d", 1, 64'h1111_2222_3333_4444);
        wait_ack("tie1_d", 10);
        wait_l2("tie1_i");
        check("tie1_second_addr", l2_addr, 64'h3000);
        serve_l2("tie1_i", 1, 64'h5555_6666_7777_8888);
        wait_ack("tie1_i", 10);

        // Repeat tie: I lost last time, so I goes first
        i_req  = 1'b1;
        i_addr = 64'h0000_0000_0000_5000;
        d_req  = 1'b1;
        d_addr = 64'h0000_0000_0000_6000;
        push_exp(1'b0, 64'h0123_4567_89AB_CDEF, 1'b0);
        push_exp(1'b1, 64'hFEDC_BA98_7654_3210, 1'b0);
        wait_l2("tie2_i");
        check("tie2_first_addr", l2_addr, 64'h5000);
        serve_l2("tie2_i", 2, 64'h0123_4567_89AB_CDEF);
        wait_ack("tie2_i", 10);
        wait_l2("tie2_d");
        check("tie2_second_addr", l2_addr, 64'h6000);
        serve_l2("tie2_d", 1, 64'hFEDC_BA98_7654_3210);
        wait_ack("tie2_d", 10);

        // Instruction read with l2_ready two cycles after l2_req
        i_req  = 1'b1;
        i_addr = 64'h1000;
        push_exp(1'b0, 64'hAAAA_BBBB_1234_5678, 1'b0);
        wait_l2("iread");
        check("iread_addr",   l2_addr, 64'h1000);
        check("iread_we",     {63'b0, l2_we}, 64'd0);
        check("iread_wdata",  l2_wdata, 64'd0);
        serve_l2("iread", 2, 64'hAAAA_BBBB_1234_5678);
        wait_ack("iread", 10);
        check("iread_hold", {32'b0, i_rdata}, 64'h1234_5678);

        // Data write
        d_req   = 1'b1;
        d_we    = 1'b1;
        d_addr  = 64'h2008;
        d_wdata = 64'hDEAD_BEEF;
        push_exp(1'b1, 64'h0, 1'b0);
        wait_l2("dwrite");
        check("dwrite_addr",  l2_addr, 64'h2008);
        check("dwrite_we",    {63'b0, l2_we}, 64'd1);
        check("dwrite_wdata", l2_wdata, 64'hDEAD_BEEF);
        serve_l2("dwrite", 3, 64'h0);
        wait_ack("dwrite", 10);
        d_we = 1'b0;

        // Minimum latency: req sampled at t, l2_req at t+1, ack at t+3
        i_req  = 1'b1;
        i_addr = 64'h7000;
        push_exp(1'b0, 64'h0000_0000_CAFE_F00D, 1'b0);
        @(negedge clk);
        check("minlat_l2_req", {63'b0, l2_req}, 64'd1);
        @(negedge clk);
        l2_ready = 1'b1;
        l2_rdata = 64'h0000_0000_CAFE_F00D;
        @(negedge clk);
        l2_ready = 1'b0;
        check("minlat_ack", {63'b0, i_ack}, 64'd1);
        i_req = 1'b0;
        @(negedge clk);

        // Timeout: ISSUE plus 255 WAIT cycles, then ack with err and zero data
        d_req  = 1'b1;
        d_addr = 64'h8000;
        push_exp(1'b1, 64'h0, 1'b1);
        req_cycles = 0;
        for (int n = 0; n < 400; n++) begin
            if (d_ack) break;
            if (l2_req) req_cycles++;
            @(negedge clk);
        end
        check("timeout_ack", {63'b0, d_ack}, 64'd1);
        check("timeout_err", {63'b0, err}, 64'd1);
        check("timeout_l2_req_cycles", req_cycles, 64'd256);
        d_req = 1'b0;
        @(negedge clk);

        // Reset during WAIT aborts with no ack
        d_req  = 1'b1;
        d_addr = 64'h9000;
        wait_l2("abort");
        @(negedge clk);
        reset = 1'b1;
        d_req = 1'b0;
        @(negedge clk);
        check("abort_busy",   {63'b0, busy},   64'd0);
        check("abort_l2_req", {63'b0, l2_req}, 64'd0);
        check("abort_d_ack",  {63'b0, d_ack},  64'd0);
        reset = 1'b0;
        repeat (3) @(negedge clk);
        check("abort_no_late_ack", {62'b0, i_ack, d_ack}, 64'd0);

        // Requester drops req mid-transaction; ack still comes
        i_req  = 1'b1;
        i_addr = 64'hA000;
        push_exp(1'b0, 64'h0000_0000_BEEF_0001, 1'b0);
        wait_l2("drop");
        check("drop_addr", l2_addr, 64'hA000);
        i_req = 1'b0;
        serve_l2("drop", 2, 64'h0000_0000_BEEF_0001);
        wait_ack("drop", 10);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", sb.size(), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
